// File: rtl/decoder_pkg.sv
// Shared types and defaults for the sequenced one-hot decoder (decoder_3x8_seq).
// Optional target-acknowledge behaviour is selected by the DEC_ACK_EN macro in the top.
package decoder_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} dec_state_t;

  localparam int DEC_N_OUT       = 8;
  localparam int DEC_HOLD_CYCLES = 4;
  localparam int DEC_GAP_CYCLES  = 1;
  localparam int DEC_MAX_OUT     = 256;

  // Widest possible one-hot; callers truncate to their own N_OUT.
  function automatic logic [DEC_MAX_OUT-1:0] idx_to_onehot(input logic [7:0] idx);
    logic [DEC_MAX_OUT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_hold_timer.sv
// Loadable down-counter that times both the strobe hold and the guard gap.
// Load wins over decrement; the count stops at zero instead of wrapping.
module dec_hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Counter register: async clear, load has priority, saturating decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_3x8_seq.sv
// Sequenced binary-to-one-hot decoder: accept an index, strobe its line for a hold time, then gap.
// Define DEC_ACK_EN to hold the strobe past its hold time until dec_ack is seen.
module decoder_3x8_seq
  import decoder_pkg::*;
#(
  parameter int N_OUT       = DEC_N_OUT,
  parameter int IDX_W       = $clog2(N_OUT),
  parameter int HOLD_CYCLES = DEC_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEC_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             dec_ack,
  output logic [N_OUT-1:0] out_onehot,
  output logic             out_active,
  output logic             err_range
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dec_state_t        state, state_nxt;
  logic [N_OUT-1:0]  onehot_nxt;
  logic              err_nxt;
  logic              accept, idx_ok, exit_ok;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]  tmr_load_val, tmr_cnt;

  // When every index value maps to a line, the range check folds away.
  generate
    if (N_OUT == (2 ** IDX_W)) begin : g_full_range
      assign idx_ok = 1'b1;
    end else begin : g_part_range
      assign idx_ok = (int'(in_idx) < N_OUT);
    end
  endgenerate

`ifdef DEC_ACK_EN
  assign exit_ok = dec_ack;
`else
  logic unused_dec_ack;
  assign unused_dec_ack = dec_ack;
  assign exit_ok        = 1'b1;
`endif

  assign in_ready   = (state == ST_IDLE);
  assign accept     = in_valid & in_ready;
  assign out_active = |out_onehot;

  dec_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // Next-state and next-output logic; the timer is reloaded at each phase entry.
  always_comb begin
    state_nxt    = state;
    onehot_nxt   = out_onehot;
    err_nxt      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (idx_ok) begin
            state_nxt    = ST_DRIVE;
            onehot_nxt   = N_OUT'(idx_to_onehot(8'(in_idx)));
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (exit_ok) begin
          onehot_nxt = '0;
          if (GAP_CYCLES > 0) begin
            state_nxt    = ST_GAP;
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        onehot_nxt = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears any strobe in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_onehot <= '0;
      err_range  <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_onehot <= onehot_nxt;
      err_range  <= err_nxt;
    end
  end

  logic [CNT_W-1:0] unused_tmr_cnt;
  assign unused_tmr_cnt = tmr_cnt;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Self-checking bench for decoder_3x8_seq: default 8-line DUT plus a 6-line DUT for range errors.
// A remaining-cycles reference model predicts every output each cycle; honours DEC_ACK_EN.
module tb_decoder_3x8_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;
`ifdef DEC_ACK_EN
  localparam bit ACK_MODE = 1'b1;
`else
  localparam bit ACK_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_idx = '0;
  logic       dec_ack = 1'b0;

  logic       rdy8, act8, err8;
  logic [7:0] oh8;
  logic       rdy6, act6, err6;
  logic [5:0] oh6;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = 8-line DUT, index 1 = 6-line DUT.
  int         hold_left [2];
  int         gap_left  [2];
  logic [7:0] cur_oh    [2];
  bit         exp_err   [2];
  int         n_lines   [2];

  always #5 clk = ~clk;

  decoder_3x8_seq #(.N_OUT(8), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_idx(in_idx),
    .dec_ack(dec_ack), .out_onehot(oh8), .out_active(act8), .err_range(err8)
  );

  decoder_3x8_seq #(.N_OUT(6), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6), .in_idx(in_idx),
    .dec_ack(dec_ack), .out_onehot(oh6), .out_active(act6), .err_range(err6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expOnehot(input int k);
    return (hold_left[k] > 0) ? cur_oh[k] : 8'h00;
  endfunction

  function automatic bit expReady(input int k);
    return (hold_left[k] == 0) && (gap_left[k] == 0);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      hold_left[k] = 0;
      gap_left[k]  = 0;
      cur_oh[k]    = 8'h00;
      exp_err[k]   = 1'b0;
    end
  endtask

  // One clock of the model, using the inputs present during that cycle.
  task automatic modelStep();
    bit rdy;
    for (int k = 0; k < 2; k++) begin
      rdy = expReady(k);
      if (hold_left[k] > 0) begin
        if (hold_left[k] > 1 || !ACK_MODE || dec_ack) hold_left[k]--;
      end else if (gap_left[k] > 0) begin
        gap_left[k]--;
      end
      exp_err[k] = 1'b0;
      if (rdy && in_valid) begin
        if (int'(in_idx) < n_lines[k]) begin
          hold_left[k] = HOLD;
          gap_left[k]  = GAP;
          cur_oh[k]    = 8'h01 << in_idx;
        end else begin
          exp_err[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("oh8",  {24'h0, oh8},        {24'h0, expOnehot(0)});
    checkOutput("act8", {31'h0, act8},       {31'h0, expOnehot(0) != 8'h00});
    checkOutput("rdy8", {31'h0, rdy8},       {31'h0, expReady(0)});
    checkOutput("err8", {31'h0, err8},       {31'h0, exp_err[0]});
    checkOutput("oh6",  {26'h0, oh6},        {24'h0, expOnehot(1)});
    checkOutput("act6", {31'h0, act6},       {31'h0, expOnehot(1) != 8'h00});
    checkOutput("rdy6", {31'h0, rdy6},       {31'h0, expReady(1)});
    checkOutput("err6", {31'h0, err6},       {31'h0, exp_err[1]});
  endtask

  // Drive one cycle's inputs (called at negedge), clock it, then check at the next negedge.
  task automatic applyStimulus(input bit v, input logic [2:0] idx, input bit ack);
    in_valid = v;
    in_idx   = idx;
    dec_ack  = ack;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_oh8",  {24'h0, oh8}, 32'h0);
    checkOutput("rst_rdy8", {31'h0, rdy8}, 32'h1);
    checkOutput("rst_err6", {31'h0, err6}, 32'h0);
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  logic [2:0] seq_idx [3];

  initial begin
    n_lines[0] = 8;
    n_lines[1] = 6;
    modelReset();
    #2;
    doReset();
    applyStimulus(1'b0, 3'd0, 1'b0);

    // Single accept of index 5: four strobe cycles, one gap cycle, then ready.
    applyStimulus(1'b1, 3'd5, 1'b1);
    checkOutput("t2_first", {24'h0, oh8}, 32'h20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("t2_last", {24'h0, oh8}, 32'h20);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("t2_gap", {24'h0, oh8}, 32'h00);
    checkOutput("t2_gap_rdy", {31'h0, rdy8}, 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("t2_rdy", {31'h0, rdy8}, 32'h1);

    // Back-to-back with valid held high: 6-cycle spacing.
    seq_idx[0] = 3'd0; seq_idx[1] = 3'd7; seq_idx[2] = 3'd2;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, seq_idx[s], 1'b1);
      checkOutput("t3_strobe", {24'h0, oh8}, 32'h1 << seq_idx[s]);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, seq_idx[s], 1'b1);
    end
    applyStimulus(1'b0, 3'd0, 1'b1);

    // Out-of-range index on the 6-line DUT.
    applyStimulus(1'b1, 3'd6, 1'b1);
    checkOutput("t5_err", {31'h0, err6}, 32'h1);
    checkOutput("t5_oh6", {26'h0, oh6}, 32'h0);
    checkOutput("t5_rdy", {31'h0, rdy6}, 32'h1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("t5_pulse", {31'h0, err6}, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'd0, 1'b1);

    // Reset during the second strobe cycle.
    applyStimulus(1'b1, 3'd3, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("t4_pre", {24'h0, oh8}, 32'h08);
    doReset();
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("t4_post_rdy", {31'h0, rdy8}, 32'h1);

    // Randomised traffic, with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
